vga_radius_engine: RTL and testbench
====================================

# vga_radius_engine

Multiplier-free geometry front end for the black-hole renderer. It sits between `hvsync_generator` and the pixel shader, and consumes the raw beam position and sync signals. It produces registered, beam-aligned squared distances from screen centre: a circular metric and a vertically squashed "flat" metric. It also produces the frame animation counter. The squares are maintained by incremental difference updates rather than multipliers. A continuity checker drops lock whenever the incoming beam position stops advancing one pixel per clock.

## Interface
Parameters:
- `CX`, 320, horizontal centre in pixels
- `CY`, 240, vertical centre in lines
- `H_TOTAL`, 800, pixels per line including blanking
- `V_TOTAL`, 525, lines per frame including blanking
- `FLAT_SHIFT`, 4, left shift applied to dy² in the flat metric

Ports:
- `clk`  in  1  pixel clock (~25 MHz)
- `rst_n`  in  1  synchronous, active-low reset
- `hpos`  in  10  beam x from the timing generator
- `vpos`  in  10  beam y from the timing generator
- `hsync`  in  1  horizontal sync, active low
- `vsync`  in  1  vertical sync, active low
- `display_on`  in  1  visible-area flag
- `dx_o`  out  11  signed, hpos − CX
- `dy_o`  out  11  signed, vpos − CY
- `r2_circ_o`  out  22  dx² + dy²
- `r2_flat_o`  out  22  dx² + (dy² << FLAT_SHIFT)
- `hsync_o`, `vsync_o`, `de_o`  out  1 each  sync and display_on delayed to match the metrics
- `frame_cnt_o`  out  16  frame counter
- `locked_o`  out  1  metric outputs are valid
- `err_o`  out  1  sticky continuity-error flag

## Operation
State machine with states UNLOCKED and LOCKED; reset enters UNLOCKED.

UNLOCKED:
- Accumulators are held.
- Metric outputs are driven to 0.
- On a cycle with hpos==0 and vpos==0, load:
  - dx = −CX, dxsq = CX²
  - dy = −CY, dysq = CY²
- After that load, go to LOCKED.

LOCKED, per cycle:
- If hpos==0, reload dx = −CX and dxsq = CX².
- Otherwise, update from the old value: dxsq += 2·dx + 1, then dx += 1.
- When hpos==0 and vpos==0, reload dy = −CY and dysq = CY².
- When hpos==0 and vpos≠0, update from the old value: dysq += 2·dy + 1, then dy += 1.
- Otherwise dy and dysq hold.

Continuity check (LOCKED only), comparing against the previous-cycle inputs:
- Expected hpos is 0 if the previous hpos was H_TOTAL−1, otherwise previous hpos + 1.
- Expected vpos changes only when the previous hpos was H_TOTAL−1. It then becomes previous vpos + 1, or 0 if the previous vpos was V_TOTAL−1.
- On any mismatch: go to UNLOCKED and set err_o.
- err_o clears only on reset.

Frame counter:
- vsync_prev is a register of vsync.
- frame_cnt increments when vsync==1 and vsync_prev==0, i.e. at the end of the sync pulse.
- It wraps from 65535 to 0.
- vsync_prev resets to 1, so a vsync held high through reset causes no count.

Widths and arithmetic:
- dx range −320..479; dy range −240..284.
- Maximum r2_flat is 1 519 937, which is below 2²², so there is no overflow.
- Accumulators are 22-bit unsigned; the increment terms are computed in 12-bit signed.

## Timing
- Latency is exactly 1 cycle. The outputs at cycle n+1 correspond to the inputs at cycle n, and all outputs are registered.
- hsync_o, vsync_o and de_o are single-register delays of their inputs, in every state.
- In LOCKED, r2_circ_o, r2_flat_o, dx_o and dy_o equal the exact products for the sampled hpos/vpos.
- locked_o rises on the cycle after the origin load: the same cycle that carries the metrics for (0,0).
- On a continuity mismatch at cycle n, at cycle n+1 locked_o=0, metric outputs=0 and err_o=1.
- Reset values:
  - r2_circ_o, r2_flat_o, dx_o, dy_o, frame_cnt_o = 0
  - locked_o = 0, err_o = 0, de_o = 0
  - hsync_o = 1, vsync_o = 1
- Reset mid-frame: the block returns to UNLOCKED and stays unlocked until the next (0,0) sample.
- A simultaneous mismatch and origin sample gives a mismatch and UNLOCKED. Relock happens at the following frame origin.

## Test plan
- Reset, then hold rst_n=0 for 3 cycles with vsync=1 → all outputs at their reset values; frame_cnt_o=0 after release.
- Drive with `hvsync_generator` for 2 full frames and compare every pixel against the multiplier golden model. Spot checks:
  - (320,240) → circ 0, flat 0
  - (0,0) → circ 160000, flat 1024000
  - (799,524) → circ 310097, flat 1519937
- Run 3 frames from reset → frame_cnt_o=3. Separately, pulse vsync low→high twice within one line → exactly +2.
- Locked stream, then hpos jumps 100→200 → next cycle locked_o=0, r2 outputs=0, err_o=1. Relock occurs one cycle after the next (0,0) sample, with err_o still 1.
- Assert rst_n=0 at hpos=400, vpos=100 for 1 cycle → err_o=0, locked_o=0 until the (0,0) sample of the next frame; metrics are correct afterwards.
- Verify output sync alignment: hsync_o falls exactly 1 cycle after hsync falls (hpos 656); de_o falls 1 cycle after display_on falls (hpos 640).

Source files
------------

// File: rtl/vga_radius_engine.sv
// Multiplier-free radius front end: tracks dx, dy and their squares by difference updates
// while the beam advances one pixel per clock; any skip drops lock and latches err_o.
module vga_radius_engine #(
  parameter int unsigned CX         = 320,
  parameter int unsigned CY         = 240,
  parameter int unsigned H_TOTAL    = 800,
  parameter int unsigned V_TOTAL    = 525,
  parameter int unsigned FLAT_SHIFT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [9:0]         hpos,
  input  logic [9:0]         vpos,
  input  logic               hsync,
  input  logic               vsync,
  input  logic               display_on,
  output logic signed [10:0] dx_o,
  output logic signed [10:0] dy_o,
  output logic [21:0]        r2_circ_o,
  output logic [21:0]        r2_flat_o,
  output logic               hsync_o,
  output logic               vsync_o,
  output logic               de_o,
  output logic [15:0]        frame_cnt_o,
  output logic               locked_o,
  output logic               err_o
);

  localparam logic signed [10:0] L_DX0   = 11'(0) - 11'(CX);
  localparam logic signed [10:0] L_DY0   = 11'(0) - 11'(CY);
  localparam logic [21:0]        L_DXSQ0 = 22'(CX * CX);
  localparam logic [21:0]        L_DYSQ0 = 22'(CY * CY);
  localparam logic [9:0]         L_H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0]         L_V_LAST = 10'(V_TOTAL - 1);

  typedef enum logic {StUnlocked, StLocked} state_e;

  state_e             r_state;
  logic signed [10:0] r_dx;
  logic signed [10:0] r_dy;
  logic [21:0]        r_dxsq;
  logic [21:0]        r_dysq;
  logic [9:0]         r_hpos_prev;
  logic [9:0]         r_vpos_prev;
  logic               r_vsync_prev;

  logic               w_origin;
  logic [9:0]         w_exp_h;
  logic [9:0]         w_exp_v;
  logic               w_mismatch;
  logic               w_go_locked;
  logic signed [11:0] w_dx_step;
  logic signed [11:0] w_dy_step;
  logic signed [10:0] w_dx_nxt;
  logic signed [10:0] w_dy_nxt;
  logic [21:0]        w_dxsq_nxt;
  logic [21:0]        w_dysq_nxt;
  logic [21:0]        w_circ;
  logic [21:0]        w_flat;

  // 2*d + 1 is just d with a 1 appended below its LSB.
  assign w_dx_step = {r_dx, 1'b1};
  assign w_dy_step = {r_dy, 1'b1};
  assign w_origin  = (hpos == 10'd0) && (vpos == 10'd0);

  always_comb begin
    w_exp_h = (r_hpos_prev == L_H_LAST) ? 10'd0 : r_hpos_prev + 10'd1;
    w_exp_v = r_vpos_prev;
    if (r_hpos_prev == L_H_LAST) begin
      w_exp_v = (r_vpos_prev == L_V_LAST) ? 10'd0 : r_vpos_prev + 10'd1;
    end
    w_mismatch  = (r_state == StLocked) && ((hpos != w_exp_h) || (vpos != w_exp_v));
    w_go_locked = (r_state == StLocked) ? !w_mismatch : w_origin;
  end

  always_comb begin
    w_dx_nxt   = r_dx;
    w_dxsq_nxt = r_dxsq;
    w_dy_nxt   = r_dy;
    w_dysq_nxt = r_dysq;
    if (r_state == StUnlocked) begin
      if (w_origin) begin
        w_dx_nxt   = L_DX0;
        w_dxsq_nxt = L_DXSQ0;
        w_dy_nxt   = L_DY0;
        w_dysq_nxt = L_DYSQ0;
      end
    end else begin
      if (hpos == 10'd0) begin
        w_dx_nxt   = L_DX0;
        w_dxsq_nxt = L_DXSQ0;
      end else begin
        w_dx_nxt   = r_dx + 11'sd1;
        w_dxsq_nxt = r_dxsq + {{10{w_dx_step[11]}}, w_dx_step};
      end
      if (w_origin) begin
        w_dy_nxt   = L_DY0;
        w_dysq_nxt = L_DYSQ0;
      end else if (hpos == 10'd0) begin
        w_dy_nxt   = r_dy + 11'sd1;
        w_dysq_nxt = r_dysq + {{10{w_dy_step[11]}}, w_dy_step};
      end
    end
    w_circ = w_dxsq_nxt + w_dysq_nxt;
    w_flat = w_dxsq_nxt + (w_dysq_nxt << FLAT_SHIFT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= StUnlocked;
      r_dx         <= '0;
      r_dy         <= '0;
      r_dxsq       <= '0;
      r_dysq       <= '0;
      r_hpos_prev  <= '0;
      r_vpos_prev  <= '0;
      r_vsync_prev <= 1'b1;
      dx_o         <= '0;
      dy_o         <= '0;
      r2_circ_o    <= '0;
      r2_flat_o    <= '0;
      hsync_o      <= 1'b1;
      vsync_o      <= 1'b1;
      de_o         <= 1'b0;
      frame_cnt_o  <= '0;
      locked_o     <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      r_hpos_prev  <= hpos;
      r_vpos_prev  <= vpos;
      r_vsync_prev <= vsync;
      hsync_o      <= hsync;
      vsync_o      <= vsync;
      de_o         <= display_on;
      r_dx         <= w_dx_nxt;
      r_dy         <= w_dy_nxt;
      r_dxsq       <= w_dxsq_nxt;
      r_dysq       <= w_dysq_nxt;
      // Count on the trailing (rising) edge of the active-low vsync pulse.
      if (vsync && !r_vsync_prev) begin
        frame_cnt_o <= frame_cnt_o + 16'd1;
      end
      if (w_mismatch) begin
        err_o <= 1'b1;
      end
      if (w_go_locked) begin
        r_state   <= StLocked;
        locked_o  <= 1'b1;
        dx_o      <= w_dx_nxt;
        dy_o      <= w_dy_nxt;
        r2_circ_o <= w_circ;
        r2_flat_o <= w_flat;
      end else begin
        r_state   <= StUnlocked;
        locked_o  <= 1'b0;
        dx_o      <= '0;
        dy_o      <= '0;
        r2_circ_o <= '0;
        r2_flat_o <= '0;
      end
    end
  end

endmodule

// File: tb/tb_vga_radius_engine.sv
// Bench for vga_radius_engine on a scaled-down raster, checked against a multiplying
// reference model of lock, error, frame count and metrics.
module tb_vga_radius_engine;

  localparam int P_CX    = 32;
  localparam int P_CY    = 20;
  localparam int P_HT    = 80;
  localparam int P_VT    = 50;
  localparam int P_FS    = 4;
  localparam int P_VIS_H = 64;
  localparam int P_VIS_V = 40;
  localparam int P_HS0   = 66;
  localparam int P_HS1   = 76;
  localparam int P_VS0   = 42;
  localparam int P_VS1   = 44;

  logic               clk;
  logic               rst_n;
  logic [9:0]         hpos;
  logic [9:0]         vpos;
  logic               hsync;
  logic               vsync;
  logic               display_on;
  logic signed [10:0] dx_o;
  logic signed [10:0] dy_o;
  logic [21:0]        r2_circ_o;
  logic [21:0]        r2_flat_o;
  logic               hsync_o;
  logic               vsync_o;
  logic               de_o;
  logic [15:0]        frame_cnt_o;
  logic               locked_o;
  logic               err_o;

  vga_radius_engine #(
    .CX        (P_CX),
    .CY        (P_CY),
    .H_TOTAL   (P_HT),
    .V_TOTAL   (P_VT),
    .FLAT_SHIFT(P_FS)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .hpos       (hpos),
    .vpos       (vpos),
    .hsync      (hsync),
    .vsync      (vsync),
    .display_on (display_on),
    .dx_o       (dx_o),
    .dy_o       (dy_o),
    .r2_circ_o  (r2_circ_o),
    .r2_flat_o  (r2_flat_o),
    .hsync_o    (hsync_o),
    .vsync_o    (vsync_o),
    .de_o       (de_o),
    .frame_cnt_o(frame_cnt_o),
    .locked_o   (locked_o),
    .err_o      (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state and expected outputs.
  logic               m_locked;
  logic               m_err;
  logic               m_vs_prev;
  logic [15:0]        m_frame;
  int                 m_ph;
  int                 m_pv;
  logic signed [10:0] e_dx;
  logic signed [10:0] e_dy;
  logic [21:0]        e_circ;
  logic [21:0]        e_flat;
  logic               e_hs;
  logic               e_vs;
  logic               e_de;
  int                 s_h;
  int                 s_v;
  int                 g_h;
  int                 g_v;
  int                 checks;
  int                 errors;
  logic               all_ok;

  assign all_ok = (dx_o === e_dx) && (dy_o === e_dy) && (r2_circ_o === e_circ) &&
                  (r2_flat_o === e_flat) && (hsync_o === e_hs) && (vsync_o === e_vs) &&
                  (de_o === e_de) && (frame_cnt_o === m_frame) &&
                  (locked_o === m_locked) && (err_o === m_err);

  function automatic logic vs_of(input int v);
    return !((v >= P_VS0) && (v < P_VS1));
  endfunction

  task automatic tick(input int h, input int v, input logic vs, input logic r);
    int nh;
    int nv;
    int dx;
    int dy;
    hpos       = 10'(h);
    vpos       = 10'(v);
    vsync      = vs;
    rst_n      = r;
    hsync      = !((h >= P_HS0) && (h < P_HS1));
    display_on = (h < P_VIS_H) && (v < P_VIS_V);
    @(posedge clk);
    #1;
    if (!r) begin
      m_locked  = 1'b0;
      m_err     = 1'b0;
      m_frame   = 16'd0;
      m_vs_prev = 1'b1;
      e_hs      = 1'b1;
      e_vs      = 1'b1;
      e_de      = 1'b0;
    end else begin
      nh = (m_ph == P_HT - 1) ? 0 : m_ph + 1;
      nv = (m_ph != P_HT - 1) ? m_pv : ((m_pv == P_VT - 1) ? 0 : m_pv + 1);
      if (m_locked && ((h != nh) || (v != nv))) begin
        m_locked = 1'b0;
        m_err    = 1'b1;
      end else if (!m_locked && (h == 0) && (v == 0)) begin
        m_locked = 1'b1;
      end
      if (vs && !m_vs_prev) m_frame = m_frame + 16'd1;
      m_vs_prev = vs;
      e_hs      = hsync;
      e_vs      = vs;
      e_de      = display_on;
    end
    m_ph = h;
    m_pv = v;
    s_h  = h;
    s_v  = v;
    if (m_locked) begin
      dx     = h - P_CX;
      dy     = v - P_CY;
      e_dx   = 11'(dx);
      e_dy   = 11'(dy);
      e_circ = 22'(dx * dx + dy * dy);
      e_flat = 22'(dx * dx + (dy * dy) * (1 << P_FS));
    end else begin
      e_dx   = '0;
      e_dy   = '0;
      e_circ = '0;
      e_flat = '0;
    end
    #1;
  endtask

  task automatic adv();
    if (g_h == P_HT - 1) begin
      g_h = 0;
      g_v = (g_v == P_VT - 1) ? 0 : g_v + 1;
    end else begin
      g_h = g_h + 1;
    end
  endtask

  task automatic gen_step();
    tick(g_h, g_v, vs_of(g_v), 1'b1);
    adv();
  endtask

  task automatic test_reset();
    g_h = 5;
    g_v = 3;
    for (int i = 0; i < 3; i++) begin
      tick(g_h, g_v, 1'b1, 1'b0);
      adv();
      checks++;
      if (r2_circ_o !== 22'd0 || r2_flat_o !== 22'd0 || dx_o !== 11'sd0 || dy_o !== 11'sd0 ||
          frame_cnt_o !== 16'd0 || locked_o !== 1'b0 || err_o !== 1'b0 || de_o !== 1'b0 ||
          hsync_o !== 1'b1 || vsync_o !== 1'b1) begin
        errors++;
        $display("FAIL reset_values: got circ=%0d flat=%0d dx=%0d dy=%0d fc=%0d lk=%b err=%b de=%b hs=%b vs=%b, want zeros with hs=vs=1",
                 r2_circ_o, r2_flat_o, dx_o, dy_o, frame_cnt_o, locked_o, err_o, de_o,
                 hsync_o, vsync_o);
      end
    end
    tick(g_h, g_v, 1'b1, 1'b1);
    adv();
    checks++;
    if (frame_cnt_o !== 16'd0 || locked_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got fc=%0d lk=%b, want fc=0 lk=0", frame_cnt_o, locked_o);
    end
  endtask

  task automatic test_frames();
    g_h = 0;
    g_v = 0;
    for (int i = 0; i < 2 * P_HT * P_VT + 1; i++) begin
      gen_step();
      checks++;
      if (!all_ok) begin
        errors++;
        $display("FAIL frames h=%0d v=%0d: got circ=%0d flat=%0d dx=%0d dy=%0d lk=%b err=%b fc=%0d, want circ=%0d flat=%0d dx=%0d dy=%0d lk=%b err=%b fc=%0d",
                 s_h, s_v, r2_circ_o, r2_flat_o, dx_o, dy_o, locked_o, err_o, frame_cnt_o,
                 e_circ, e_flat, e_dx, e_dy, m_locked, m_err, m_frame);
      end
      if (s_h == P_CX && s_v == P_CY) begin
        checks++;
        if (r2_circ_o !== 22'd0 || r2_flat_o !== 22'd0) begin
          errors++;
          $display("FAIL spot_centre: got circ=%0d flat=%0d, want 0 0", r2_circ_o, r2_flat_o);
        end
      end
      if (s_h == 0 && s_v == 0) begin
        checks++;
        if (r2_circ_o !== 22'd1424 || r2_flat_o !== 22'd7424) begin
          errors++;
          $display("FAIL spot_origin: got circ=%0d flat=%0d, want 1424 7424",
                   r2_circ_o, r2_flat_o);
        end
      end
      if (s_h == P_HT - 1 && s_v == P_VT - 1) begin
        checks++;
        if (r2_circ_o !== 22'd3050 || r2_flat_o !== 22'd15665) begin
          errors++;
          $display("FAIL spot_corner: got circ=%0d flat=%0d, want 3050 15665",
                   r2_circ_o, r2_flat_o);
        end
      end
    end
  endtask

  task automatic test_frame_count();
    tick(g_h, g_v, 1'b1, 1'b0);
    g_h = 0;
    g_v = 0;
    for (int i = 0; i < 3 * P_HT * P_VT; i++) gen_step();
    checks++;
    if (frame_cnt_o !== 16'd3) begin
      errors++;
      $display("FAIL frame_count: got %0d, want 3", frame_cnt_o);
    end
  endtask

  task automatic test_vsync_pulses();
    logic [15:0] base;
    logic [3:0]  pat;
    for (int i = 0; i < 2000 && !(g_v == 5 && g_h == 10); i++) gen_step();
    base = m_frame;
    pat  = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      tick(g_h, g_v, pat[k], 1'b1);
      adv();
    end
    gen_step();
    checks++;
    if (frame_cnt_o !== base + 16'd2) begin
      errors++;
      $display("FAIL vsync_double_pulse: got %0d, want %0d", frame_cnt_o, base + 16'd2);
    end
  endtask

  task automatic test_sync_align();
    for (int i = 0; i < 2 * P_HT && g_h != P_VIS_H - 1; i++) gen_step();
    gen_step();
    checks++;
    if (de_o !== 1'b1) begin
      errors++;
      $display("FAIL de_before_fall h=%0d: got %b, want 1", s_h, de_o);
    end
    gen_step();
    checks++;
    if (de_o !== 1'b0) begin
      errors++;
      $display("FAIL de_after_fall h=%0d: got %b, want 0", s_h, de_o);
    end
    for (int i = 0; i < P_HT && g_h != P_HS0 - 1; i++) gen_step();
    gen_step();
    checks++;
    if (hsync_o !== 1'b1) begin
      errors++;
      $display("FAIL hsync_before_fall h=%0d: got %b, want 1", s_h, hsync_o);
    end
    gen_step();
    checks++;
    if (hsync_o !== 1'b0) begin
      errors++;
      $display("FAIL hsync_after_fall h=%0d: got %b, want 0", s_h, hsync_o);
    end
  endtask

  task automatic run_to_origin(input string name, output logic found);
    found = 1'b0;
    for (int i = 0; i < P_HT * P_VT + 10 && !found; i++) begin
      gen_step();
      checks++;
      if (!all_ok) begin
        errors++;
        $display("FAIL %s h=%0d v=%0d: got circ=%0d lk=%b err=%b, want circ=%0d lk=%b err=%b",
                 name, s_h, s_v, r2_circ_o, locked_o, err_o, e_circ, m_locked, m_err);
      end
      if (s_h == 0 && s_v == 0) found = 1'b1;
    end
  endtask

  task automatic test_glitch();
    logic found;
    for (int i = 0; i < 2 * P_HT && g_h != 30; i++) gen_step();
    gen_step();
    g_h = 50;
    gen_step();
    checks++;
    if (locked_o !== 1'b0 || r2_circ_o !== 22'd0 || r2_flat_o !== 22'd0 || err_o !== 1'b1) begin
      errors++;
      $display("FAIL glitch_drop: got lk=%b circ=%0d flat=%0d err=%b, want 0 0 0 1",
               locked_o, r2_circ_o, r2_flat_o, err_o);
    end
    run_to_origin("glitch_wait", found);
    checks++;
    if (!found || locked_o !== 1'b1 || err_o !== 1'b1 || r2_circ_o !== 22'd1424) begin
      errors++;
      $display("FAIL glitch_relock: got found=%b lk=%b err=%b circ=%0d, want 1 1 1 1424",
               found, locked_o, err_o, r2_circ_o);
    end
  endtask

  task automatic test_back_to_back();
    logic found;
    for (int i = 0; i < 4 * P_HT && !(g_h == 30 && g_v == 2); i++) gen_step();
    gen_step();
    g_h = 0;
    g_v = 0;
    gen_step();
    checks++;
    if (locked_o !== 1'b0 || err_o !== 1'b1 || r2_circ_o !== 22'd0) begin
      errors++;
      $display("FAIL origin_mismatch: got lk=%b err=%b circ=%0d, want 0 1 0",
               locked_o, err_o, r2_circ_o);
    end
    run_to_origin("origin_mismatch_wait", found);
    checks++;
    if (!found || locked_o !== 1'b1 || r2_circ_o !== 22'd1424) begin
      errors++;
      $display("FAIL origin_mismatch_relock: got found=%b lk=%b circ=%0d, want 1 1 1424",
               found, locked_o, r2_circ_o);
    end
  endtask

  task automatic test_reset_midframe();
    logic found;
    for (int i = 0; i < P_HT * P_VT && !(g_h == 40 && g_v == 10); i++) gen_step();
    tick(g_h, g_v, vs_of(g_v), 1'b0);
    adv();
    checks++;
    if (err_o !== 1'b0 || locked_o !== 1'b0) begin
      errors++;
      $display("FAIL midframe_reset: got err=%b lk=%b, want 0 0", err_o, locked_o);
    end
    run_to_origin("midframe_wait", found);
    checks++;
    if (!found || locked_o !== 1'b1 || err_o !== 1'b0 || r2_flat_o !== 22'd7424) begin
      errors++;
      $display("FAIL midframe_relock: got found=%b lk=%b err=%b flat=%0d, want 1 1 0 7424",
               found, locked_o, err_o, r2_flat_o);
    end
    for (int i = 0; i < 200; i++) begin
      gen_step();
      checks++;
      if (!all_ok) begin
        errors++;
        $display("FAIL midframe_after h=%0d v=%0d: got circ=%0d flat=%0d, want %0d %0d",
                 s_h, s_v, r2_circ_o, r2_flat_o, e_circ, e_flat);
      end
    end
  endtask

  task automatic test_random();
    int n;
    int ev;
    for (int it = 0; it < 12; it++) begin
      n = int'($urandom_range(20, 1200));
      for (int i = 0; i < n; i++) begin
        gen_step();
        checks++;
        if (!all_ok) begin
          errors++;
          $display("FAIL random it=%0d h=%0d v=%0d: got circ=%0d flat=%0d dx=%0d dy=%0d lk=%b err=%b fc=%0d, want circ=%0d flat=%0d dx=%0d dy=%0d lk=%b err=%b fc=%0d",
                   it, s_h, s_v, r2_circ_o, r2_flat_o, dx_o, dy_o, locked_o, err_o,
                   frame_cnt_o, e_circ, e_flat, e_dx, e_dy, m_locked, m_err, m_frame);
        end
      end
      ev = int'($urandom_range(0, 3));
      if (ev == 0) begin
        g_h = int'($urandom_range(0, P_HT - 1));
        g_v = int'($urandom_range(0, P_VT - 1));
      end else if (ev == 1) begin
        tick(g_h, g_v, vs_of(g_v), 1'b0);
        adv();
      end else if (ev == 2) begin
        g_h = P_HT - 1;
        g_v = P_VT - 1;
      end
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    checks     = 0;
    errors     = 0;
    m_locked   = 1'b0;
    m_err      = 1'b0;
    m_vs_prev  = 1'b1;
    m_frame    = 16'd0;
    m_ph       = 0;
    m_pv       = 0;
    e_dx       = '0;
    e_dy       = '0;
    e_circ     = '0;
    e_flat     = '0;
    e_hs       = 1'b1;
    e_vs       = 1'b1;
    e_de       = 1'b0;
    s_h        = 0;
    s_v        = 0;
    g_h        = 0;
    g_v        = 0;
    rst_n      = 1'b0;
    hpos       = '0;
    vpos       = '0;
    hsync      = 1'b1;
    vsync      = 1'b1;
    display_on = 1'b0;
    test_reset();
    test_frames();
    test_frame_count();
    test_vsync_pulses();
    test_sync_align();
    test_glitch();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
